// File: rtl/i2c_master_nbyte_if.sv
// Request/response bundle between the config sequencer and the I2C controller.
// The sequencer drives the master modport, the controller uses the slave modport.
interface i2c_master_nbyte_if #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned NB_W      = $clog2(MAX_BYTES + 1)
);
  logic                   GO;
  logic                   RW;
  logic [6:0]             SLAVE_ADDR;
  logic [NB_W-1:0]        NBYTES;
  logic [8*MAX_BYTES-1:0] WDATA;
  logic [8*MAX_BYTES-1:0] RDATA;
  logic                   END;
  logic                   ACK;

  modport master (
    output GO, RW, SLAVE_ADDR, NBYTES, WDATA,
    input  RDATA, END, ACK
  );

  modport slave (
    input  GO, RW, SLAVE_ADDR, NBYTES, WDATA,
    output RDATA, END, ACK
  );
endinterface

// File: rtl/i2c_master_nbyte.sv
// Single-master I2C controller: START, 7-bit address + R/W, 0..MAX_BYTES data
// bytes (write or read), STOP. Open-drain SCL/SDA, SCL quarter = CLK_DIV clocks.
module i2c_master_nbyte #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic              CLOCK,
  input  logic              RESET,
  i2c_master_nbyte_if.slave bus,
  output wire               I2C_SCLK,
  inout  wire               I2C_SDAT
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW    = 8 * MAX_BYTES;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_BIT    = 3'd2;
  localparam logic [2:0] S_ACKBIT = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]      state_q,   state_n;
  logic [1:0]      quarter_q, quarter_n;
  logic [DIV_W-1:0] div_q,    div_n;
  logic [2:0]      bit_q,     bit_n;
  logic [NB_W-1:0] byte_q,    byte_n;
  logic            is_addr_q, is_addr_n;
  logic            rw_q,      rw_n;
  logic [6:0]      addr_q,    addr_n;
  logic [NB_W-1:0] nb_q,      nb_n;
  logic [DW-1:0]   wdata_q,   wdata_n;
  logic [DW-1:0]   rdata_q,   rdata_n;
  logic [6:0]      rx_q,      rx_n;
  logic            end_q,     end_n;
  logic            ack_q,     ack_n;
  logic            scl_oe_q,  scl_oe_n;
  logic            sda_oe_q,  sda_oe_n;

  logic            tick_c, sample_c, last_c, sda_in_c;
  logic [7:0]      tx_byte_c;

  // Open-drain pads: only ever pull low or release.
  assign I2C_SCLK  = scl_oe_q ? 1'b0 : 1'bz;
  assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in_c  = I2C_SDAT;

  assign bus.RDATA = rdata_q;
  assign bus.END   = end_q;
  assign bus.ACK   = ack_q;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      quarter_q <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      is_addr_q <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      nb_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rx_q      <= '0;
      end_q     <= 1'b1;
      ack_q     <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      quarter_q <= quarter_n;
      div_q     <= div_n;
      bit_q     <= bit_n;
      byte_q    <= byte_n;
      is_addr_q <= is_addr_n;
      rw_q      <= rw_n;
      addr_q    <= addr_n;
      nb_q      <= nb_n;
      wdata_q   <= wdata_n;
      rdata_q   <= rdata_n;
      rx_q      <= rx_n;
      end_q     <= end_n;
      ack_q     <= ack_n;
      scl_oe_q  <= scl_oe_n;
      sda_oe_q  <= sda_oe_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    quarter_n = quarter_q;
    div_n     = div_q;
    bit_n     = bit_q;
    byte_n    = byte_q;
    is_addr_n = is_addr_q;
    rw_n      = rw_q;
    addr_n    = addr_q;
    nb_n      = nb_q;
    wdata_n   = wdata_q;
    rdata_n   = rdata_q;
    rx_n      = rx_q;
    end_n     = end_q;
    ack_n     = ack_q;
    scl_oe_n  = 1'b0;
    sda_oe_n  = 1'b0;
    tx_byte_c = 8'h00;

    tick_c   = (div_q == DIV_W'(CLK_DIV - 1));
    sample_c = tick_c && (quarter_q == 2'd2);
    last_c   = tick_c && (quarter_q == 2'd3);

    // Divider and quarter counter only run while a frame is on the wire.
    if (state_q != S_IDLE) begin
      div_n = tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) quarter_n = quarter_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        div_n     = '0;
        quarter_n = '0;
        if (bus.GO) begin
          state_n   = S_START;
          rw_n      = bus.RW;
          addr_n    = bus.SLAVE_ADDR;
          nb_n      = (bus.NBYTES > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : bus.NBYTES;
          wdata_n   = bus.WDATA;
          rdata_n   = '0;
          rx_n      = '0;
          ack_n     = 1'b0;
          end_n     = 1'b0;
          is_addr_n = 1'b1;
          bit_n     = 3'd7;
          byte_n    = '0;
        end
      end
      S_START: begin
        if (last_c) state_n = S_BIT;
      end
      S_BIT: begin
        if (sample_c && !is_addr_q && rw_q) begin
          rx_n = {rx_q[5:0], sda_in_c};
          if (bit_q == 3'd0) rdata_n[32'(byte_q)*8 +: 8] = {rx_q, sda_in_c};
        end
        if (last_c) begin
          if (bit_q == 3'd0) state_n = S_ACKBIT;
          else               bit_n   = bit_q - 3'd1;
        end
      end
      S_ACKBIT: begin
        // Read-mode data ACK slots are our own drive, so only address/write slots count.
        if (sample_c && sda_in_c && (is_addr_q || !rw_q)) ack_n = 1'b1;
        if (last_c) begin
          bit_n = 3'd7;
          if (ack_q) begin
            state_n = S_STOP;
          end else if (is_addr_q) begin
            if (nb_q == '0) begin
              state_n = S_STOP;
            end else begin
              state_n   = S_BIT;
              is_addr_n = 1'b0;
              byte_n    = '0;
            end
          end else if (byte_q + NB_W'(1) == nb_q) begin
            state_n = S_STOP;
          end else begin
            state_n = S_BIT;
            byte_n  = byte_q + NB_W'(1);
          end
        end
      end
      S_STOP: begin
        if (last_c) begin
          state_n = S_IDLE;
          end_n   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Pad drive for the phase being entered, so pins line up with quarters.
    tx_byte_c = is_addr_n ? {addr_n, rw_n} : wdata_n[32'(byte_n)*8 +: 8];
    case (state_n)
      S_START: begin
        sda_oe_n = (quarter_n != 2'd0);
      end
      S_BIT: begin
        scl_oe_n = (quarter_n < 2'd2);
        sda_oe_n = (is_addr_n || !rw_n) && !tx_byte_c[bit_n];
      end
      S_ACKBIT: begin
        scl_oe_n = (quarter_n < 2'd2);
        sda_oe_n = !is_addr_n && rw_n && (byte_n + NB_W'(1) != nb_n);
      end
      S_STOP: begin
        scl_oe_n = (quarter_n == 2'd0);
        sda_oe_n = (quarter_n < 2'd2);
      end
      default: begin
        scl_oe_n = 1'b0;
        sda_oe_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Directed bench for i2c_master_nbyte: pin-level monitor plus a simple ACKing
// slave on SCL edges, one task per scenario.
module tb_i2c_master_nbyte;

  logic clk = 1'b0;
  logic rst_n;
  wire  scl, sda, scl3, sda3;

  pullup pu_scl  (scl);
  pullup pu_sda  (sda);
  pullup pu_scl3 (scl3);
  pullup pu_sda3 (sda3);

  i2c_master_nbyte_if #(.MAX_BYTES(4)) bus  ();
  i2c_master_nbyte_if #(.MAX_BYTES(4)) bus3 ();

  i2c_master_nbyte #(.MAX_BYTES(4), .CLK_DIV(1)) dut (
    .CLOCK(clk), .RESET(rst_n), .bus(bus), .I2C_SCLK(scl), .I2C_SDAT(sda));

  i2c_master_nbyte #(.MAX_BYTES(4), .CLK_DIV(3)) dut3 (
    .CLOCK(clk), .RESET(rst_n), .bus(bus3), .I2C_SCLK(scl3), .I2C_SDAT(sda3));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model configuration (written by tasks only).
  logic       slave_en;
  logic       s_addr_ack;
  logic       s_read;
  logic [7:0] s_data_ack;
  logic [7:0] s_rbytes [0:3];
  int         s_nrd;

  // Monitor / slave state (written by the monitor only).
  logic       s_drive = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       mon_bits [0:63];
  int         mon_n = 0, fall_n = 0, start_cnt = 0, stop_cnt = 0;

  assign sda = (s_drive && slave_en) ? 1'b0 : 1'bz;

  function automatic logic slave_bit(input int k);
    int b, p;
    b = k / 9;
    p = k % 9;
    if (p == 8) begin
      if (b == 0) return s_addr_ack;
      if (s_read) return 1'b0;
      return (b - 1 < 8) ? s_data_ack[b-1] : 1'b0;
    end
    if (b >= 1 && s_read && b - 1 < s_nrd && b - 1 < 4) return !s_rbytes[b-1][7-p];
    return 1'b0;
  endfunction

  function automatic logic [7:0] mon_byte(input int idx);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = mon_bits[9*idx + i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (!slave_en) s_drive <= 1'b0;
    if (scl_p && scl && sda_p && !sda) begin
      start_cnt <= start_cnt + 1;
      mon_n     <= 0;
      fall_n    <= 0;
    end else begin
      if (scl_p && scl && !sda_p && sda) stop_cnt <= stop_cnt + 1;
      if (!scl_p && scl) begin
        if (mon_n < 64) mon_bits[mon_n] <= sda;
        mon_n <= mon_n + 1;
      end
      if (scl_p && !scl && slave_en) begin
        s_drive <= slave_bit(fall_n);
        fall_n  <= fall_n + 1;
      end
    end
    scl_p <= scl;
    sda_p <= sda;
  end

  task automatic set_slave(input logic aa, input logic rd, input logic [7:0] dack);
    slave_en   = 1'b1;
    s_addr_ack = aa;
    s_read     = rd;
    s_data_ack = dack;
  endtask

  // Issues one request on the CLK_DIV=1 instance and counts END-low cycles.
  task automatic run_xfer(input logic rw_i, input logic [6:0] a, input logic [2:0] n,
                          input logic [31:0] wd, input int pulse_at, output int low);
    @(negedge clk);
    bus.RW = rw_i; bus.SLAVE_ADDR = a; bus.NBYTES = n; bus.WDATA = wd; bus.GO = 1'b1;
    @(negedge clk);
    bus.GO = 1'b0;
    low = 0;
    while (bus.END === 1'b0 && low < 4000) begin
      low++;
      bus.GO = (low == pulse_at);
      @(negedge clk);
    end
    bus.GO = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.END !== 1'b1) begin n_fail++; $display("FAIL reset_end: got %b expected 1", bus.END); end
    n_checks++; if (bus.ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ACK); end
    n_checks++; if (bus.RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.RDATA); end
    n_checks++; if (scl !== 1'b1 || sda !== 1'b1) begin n_fail++; $display("FAIL reset_pins: got scl=%b sda=%b expected 1/1", scl, sda); end
  endtask

  task automatic test_write;
    int low, s0, p0;
    set_slave(1'b1, 1'b0, 8'hFF);
    s0 = start_cnt; p0 = stop_cnt;
    run_xfer(1'b0, 7'h1A, 3'd2, 32'h0000_420E, -1, low);
    n_checks++; if (low != 116) begin n_fail++; $display("FAIL write_latency: got %0d expected 116", low); end
    n_checks++; if (bus.ACK !== 1'b0) begin n_fail++; $display("FAIL write_ack: got %b expected 0", bus.ACK); end
    n_checks++; if (mon_byte(0) !== 8'h34) begin n_fail++; $display("FAIL write_addr: got %h expected 34", mon_byte(0)); end
    n_checks++; if (mon_byte(1) !== 8'h0E) begin n_fail++; $display("FAIL write_b0: got %h expected 0e", mon_byte(1)); end
    n_checks++; if (mon_byte(2) !== 8'h42) begin n_fail++; $display("FAIL write_b1: got %h expected 42", mon_byte(2)); end
    n_checks++; if (mon_n != 28) begin n_fail++; $display("FAIL write_scl_rises: got %0d expected 28", mon_n); end
    n_checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin n_fail++;
      $display("FAIL write_start_stop: got %0d/%0d expected 1/1", start_cnt - s0, stop_cnt - p0); end
  endtask

  task automatic test_write_addr_nack;
    int low, p0;
    set_slave(1'b0, 1'b0, 8'hFF);
    p0 = stop_cnt;
    run_xfer(1'b0, 7'h1A, 3'd2, 32'h0000_420E, -1, low);
    n_checks++; if (low != 44) begin n_fail++; $display("FAIL addr_nack_latency: got %0d expected 44", low); end
    n_checks++; if (bus.ACK !== 1'b1) begin n_fail++; $display("FAIL addr_nack_ack: got %b expected 1", bus.ACK); end
    n_checks++; if (mon_n != 10 || stop_cnt - p0 != 1) begin n_fail++;
      $display("FAIL addr_nack_frame: got rises=%0d stops=%0d expected 10/1", mon_n, stop_cnt - p0); end
  endtask

  task automatic test_write_data_nack;
    int low;
    set_slave(1'b1, 1'b0, 8'h00);
    run_xfer(1'b0, 7'h1A, 3'd3, 32'h0033_2211, -1, low);
    n_checks++; if (low != 80) begin n_fail++; $display("FAIL data_nack_latency: got %0d expected 80", low); end
    n_checks++; if (bus.ACK !== 1'b1) begin n_fail++; $display("FAIL data_nack_ack: got %b expected 1", bus.ACK); end
    n_checks++; if (mon_n != 19) begin n_fail++; $display("FAIL data_nack_rises: got %0d expected 19", mon_n); end
  endtask

  task automatic test_read;
    int low;
    set_slave(1'b1, 1'b1, 8'h00);
    s_rbytes[0] = 8'hA5; s_rbytes[1] = 8'h3C; s_nrd = 2;
    run_xfer(1'b1, 7'h1A, 3'd2, 32'hFFFF_FFFF, -1, low);
    n_checks++; if (low != 116) begin n_fail++; $display("FAIL read_latency: got %0d expected 116", low); end
    n_checks++; if (mon_byte(0) !== 8'h35) begin n_fail++; $display("FAIL read_addr: got %h expected 35", mon_byte(0)); end
    n_checks++; if (mon_bits[17] !== 1'b0 || mon_bits[26] !== 1'b1) begin n_fail++;
      $display("FAIL read_master_ack: got %b/%b expected 0/1", mon_bits[17], mon_bits[26]); end
    n_checks++; if (bus.RDATA !== 32'h0000_3CA5) begin n_fail++; $display("FAIL read_rdata: got %h expected 00003ca5", bus.RDATA); end
    n_checks++; if (bus.ACK !== 1'b0) begin n_fail++; $display("FAIL read_ack: got %b expected 0", bus.ACK); end
  endtask

  task automatic test_probe_div3;
    int low;
    @(negedge clk);
    bus3.RW = 1'b0; bus3.SLAVE_ADDR = 7'h1A; bus3.NBYTES = 3'd0; bus3.WDATA = '0; bus3.GO = 1'b1;
    @(negedge clk);
    bus3.GO = 1'b0;
    low = 0;
    while (bus3.END === 1'b0 && low < 4000) begin low++; @(negedge clk); end
    n_checks++; if (low != 132) begin n_fail++; $display("FAIL probe_div3_latency: got %0d expected 132", low); end
    n_checks++; if (bus3.ACK !== 1'b1) begin n_fail++; $display("FAIL probe_div3_ack: got %b expected 1", bus3.ACK); end
  endtask

  task automatic test_clamp;
    int low;
    set_slave(1'b1, 1'b0, 8'hFF);
    run_xfer(1'b0, 7'h1A, 3'd7, 32'h4433_2211, -1, low);
    n_checks++; if (low != 188) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 188", low); end
    n_checks++; if (mon_n != 46) begin n_fail++; $display("FAIL clamp_rises: got %0d expected 46", mon_n); end
    n_checks++; if (mon_byte(4) !== 8'h44) begin n_fail++; $display("FAIL clamp_last_byte: got %h expected 44", mon_byte(4)); end
  endtask

  task automatic test_go_ignored;
    int low, hi;
    set_slave(1'b1, 1'b0, 8'hFF);
    run_xfer(1'b0, 7'h1A, 3'd1, 32'h0000_0055, 30, low);
    n_checks++; if (low != 80) begin n_fail++; $display("FAIL go_ignored_latency: got %0d expected 80", low); end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.END === 1'b1) hi++;
      @(negedge clk);
    end
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL go_ignored_idle: got %0d expected 4", hi); end
  endtask

  task automatic test_back_to_back;
    int low;
    set_slave(1'b1, 1'b0, 8'hFF);
    @(negedge clk);
    bus.RW = 1'b0; bus.SLAVE_ADDR = 7'h1A; bus.NBYTES = 3'd0; bus.GO = 1'b1;
    @(negedge clk);
    bus.SLAVE_ADDR = 7'h2B;
    low = 0;
    while (bus.END === 1'b0 && low < 4000) begin low++; @(negedge clk); end
    n_checks++; if (low != 44) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 44", low); end
    n_checks++; if (mon_byte(0) !== 8'h34) begin n_fail++; $display("FAIL b2b_first_addr: got %h expected 34", mon_byte(0)); end
    @(negedge clk);
    n_checks++; if (bus.END !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got END=%b expected 0", bus.END); end
    bus.GO = 1'b0;
    low = 1;
    @(negedge clk);
    while (bus.END === 1'b0 && low < 4000) begin low++; @(negedge clk); end
    n_checks++; if (low != 44) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 44", low); end
    n_checks++; if (mon_byte(0) !== 8'h56) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 56", mon_byte(0)); end
  endtask

  task automatic test_reset_mid;
    int low;
    set_slave(1'b1, 1'b1, 8'h00);
    s_rbytes[0] = 8'hA5; s_rbytes[1] = 8'h3C; s_nrd = 2;
    @(negedge clk);
    bus.RW = 1'b1; bus.SLAVE_ADDR = 7'h1A; bus.NBYTES = 3'd2; bus.GO = 1'b1;
    @(negedge clk);
    bus.GO = 1'b0;
    repeat (84) @(negedge clk);
    n_checks++; if (bus.RDATA[7:0] !== 8'hA5) begin n_fail++; $display("FAIL midreset_pre_rdata: got %h expected a5", bus.RDATA[7:0]); end
    rst_n = 1'b0;
    slave_en = 1'b0;
    @(negedge clk);
    n_checks++; if (scl !== 1'b1 || sda !== 1'b1) begin n_fail++; $display("FAIL midreset_pins: got scl=%b sda=%b expected 1/1", scl, sda); end
    n_checks++; if (bus.END !== 1'b1 || bus.ACK !== 1'b0) begin n_fail++; $display("FAIL midreset_status: got END=%b ACK=%b expected 1/0", bus.END, bus.ACK); end
    n_checks++; if (bus.RDATA !== 32'h0) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 0", bus.RDATA); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_slave(1'b1, 1'b0, 8'hFF);
    run_xfer(1'b0, 7'h1A, 3'd2, 32'h0000_420E, -1, low);
    n_checks++; if (low != 116) begin n_fail++; $display("FAIL postreset_latency: got %0d expected 116", low); end
    n_checks++; if (mon_byte(1) !== 8'h0E || bus.ACK !== 1'b0) begin n_fail++;
      $display("FAIL postreset_frame: got b0=%h ACK=%b expected 0e/0", mon_byte(1), bus.ACK); end
  endtask

  initial begin
    slave_en = 1'b0; s_addr_ack = 1'b0; s_read = 1'b0; s_data_ack = 8'h00; s_nrd = 0;
    for (int i = 0; i < 4; i++) s_rbytes[i] = 8'h00;
    bus.GO = 1'b0;  bus.RW = 1'b0;  bus.SLAVE_ADDR = '0;  bus.NBYTES = '0;  bus.WDATA = '0;
    bus3.GO = 1'b0; bus3.RW = 1'b0; bus3.SLAVE_ADDR = '0; bus3.NBYTES = '0; bus3.WDATA = '0;
    test_reset();
    test_write();
    test_write_addr_nack();
    test_write_data_nack();
    test_read();
    test_probe_div3();
    test_clamp();
    test_go_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
